// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences each instruction through
// fetch/decode/execute/writeback and drives the datapath enables and selects.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                         ALU_OR  = 4'b0001, ALU_SLT = 4'b0111, ALU_J   = 4'b1111;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_J = 6'b000010;

  state_t state_reg, state_next;
  logic   illegal_reg, illegal_next;
  logic   r_valid;
  logic [3:0] r_alu;

  assign state      = state_reg;
  assign illegal_op = illegal_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    r_valid = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = S_FETCH;
    illegal_next = illegal_reg;
    pc_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    ext_zero     = 1'b0;
    pc_src       = 2'b00;
    alu_control  = ALU_ADD;
    instr_done   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:             state_next = S_EXEC;
          OP_LW, OP_SW:     state_next = S_MEMADR;
          OP_BEQ, OP_BNE:   state_next = S_BRANCH;
          OP_ADDI, OP_ANDI: state_next = S_IMMEX;
          OP_J:             state_next = S_JUMP;
          default: begin
            illegal_next = 1'b1;
            instr_done   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        if (r_valid) begin
          state_next = S_ALUWB;
        end else begin
          illegal_next = 1'b1;
          instr_done   = 1'b1;
        end
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
        instr_done  = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        ext_zero    = (opcode == OP_ANDI);
        alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        state_next  = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        ext_zero   = (opcode == OP_ANDI);
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src      = 2'b10;
        pc_write    = 1'b1;
        alu_control = ALU_J;
        instr_done  = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
    // Enables are gated combinationally so they drop the moment reset rises.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// control words from the instruction-level rules and compared cycle by cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_write, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control, state;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_ill;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_src(pc_src), .alu_control(alu_control), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] observed();
    return {state, pc_write, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, ext_zero, pc_src, alu_control, instr_done};
  endfunction

  // Control word built from named fields; anything not mentioned is zero.
  function automatic logic [22:0] mk(input int st, input bit pcw, input bit iord, input bit mw,
                                     input bit irw, input bit rd, input bit m2r, input bit rw,
                                     input bit sa, input logic [1:0] sb, input bit ez,
                                     input logic [1:0] ps, input logic [3:0] alu, input bit done);
    return {st[3:0], pcw, iord, mw, irw, rd, m2r, rw, sa, sb, ez, ps, alu, done};
  endfunction

  // Expected per-cycle words for one instruction, plus which cycle flags it illegal.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z);
    logic [22:0] exp_q[$];
    int          ill_step;
    logic [3:0]  ralu;
    bit          rok;
    ill_step = -1;
    opcode = op; funct = fn; zero = z;
    exp_q.push_back(mk(0, 1,0,0,1,0,0,0, 0, 2'b01, 0, 2'b00, 4'b0010, 0));
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b001100, 6'b000010:
        exp_q.push_back(mk(1, 0,0,0,0,0,0,0, 0, 2'b11, 0, 2'b00, 4'b0010, 0));
      default: begin
        exp_q.push_back(mk(1, 0,0,0,0,0,0,0, 0, 2'b11, 0, 2'b00, 4'b0010, 1));
        ill_step = 1;
      end
    endcase
    case (op)
      6'b100011: begin
        exp_q.push_back(mk(2, 0,0,0,0,0,0,0, 1, 2'b10, 0, 2'b00, 4'b0010, 0));
        exp_q.push_back(mk(3, 0,1,0,0,0,0,0, 0, 2'b00, 0, 2'b00, 4'b0010, 0));
        exp_q.push_back(mk(4, 0,0,0,0,0,1,1, 0, 2'b00, 0, 2'b00, 4'b0010, 1));
      end
      6'b101011: begin
        exp_q.push_back(mk(2, 0,0,0,0,0,0,0, 1, 2'b10, 0, 2'b00, 4'b0010, 0));
        exp_q.push_back(mk(5, 0,1,1,0,0,0,0, 0, 2'b00, 0, 2'b00, 4'b0010, 1));
      end
      6'b000000: begin
        rok = 1'b1;
        case (fn)
          6'b100000: ralu = 4'b0010;
          6'b100010: ralu = 4'b0110;
          6'b100100: ralu = 4'b0000;
          6'b100101: ralu = 4'b0001;
          6'b101010: ralu = 4'b0111;
          default: begin ralu = 4'b0010; rok = 1'b0; end
        endcase
        exp_q.push_back(mk(6, 0,0,0,0,0,0,0, 1, 2'b00, 0, 2'b00, ralu, !rok));
        if (rok) exp_q.push_back(mk(7, 0,0,0,0,1,0,1, 0, 2'b00, 0, 2'b00, 4'b0010, 1));
        else     ill_step = 2;
      end
      6'b000100, 6'b000101:
        exp_q.push_back(mk(8, (op == 6'b000100) ? z : !z, 0,0,0,0,0,0, 1, 2'b00, 0,
                           2'b01, 4'b0110, 1));
      6'b001000, 6'b001100: begin
        exp_q.push_back(mk(9, 0,0,0,0,0,0,0, 1, 2'b10, op == 6'b001100, 2'b00,
                           (op == 6'b001100) ? 4'b0000 : 4'b0010, 0));
        exp_q.push_back(mk(10, 0,0,0,0,0,0,1, 0, 2'b00, op == 6'b001100, 2'b00, 4'b0010, 1));
      end
      6'b000010:
        exp_q.push_back(mk(11, 1,0,0,0,0,0,0, 0, 2'b00, 0, 2'b10, 4'b1111, 1));
      default: ;
    endcase
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      check($sformatf("op%b fn%b z%0d cyc%0d", op, fn, z, i), {9'd0, observed()}, {9'd0, exp_q[i]});
      check($sformatf("illegal op%b cyc%0d", op, i), {31'd0, illegal_op}, {31'd0, model_ill});
      if (i == ill_step) model_ill = 1'b1;
      @(negedge clk);
    end
    $display("instr op=%b fn=%b z=%0d cycles=%0d illegal=%0d", op, fn, z, exp_q.size(), model_ill);
  endtask

  logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b000101, 6'b001000, 6'b001100, 6'b000010};
  logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    model_ill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // In reset: FETCH selects, every enable and done forced low.
    check("reset word", {9'd0, observed()},
          {9'd0, mk(0, 0,0,0,0,0,0,0, 0, 2'b01, 0, 2'b00, 4'b0010, 0)});
    check("reset illegal", {31'd0, illegal_op}, 32'd0);
    reset = 1'b0;

    run_instr(6'b100011, 6'b000000, 0);
    run_instr(6'b101011, 6'b000000, 0);
    for (int k = 0; k < 5; k++) run_instr(6'b000000, legal_fns[k], 0);
    run_instr(6'b000100, 6'b000000, 1);
    run_instr(6'b000100, 6'b000000, 0);
    run_instr(6'b000101, 6'b000000, 1);
    run_instr(6'b000101, 6'b000000, 0);
    run_instr(6'b001000, 6'b000000, 0);
    run_instr(6'b001100, 6'b000000, 0);
    run_instr(6'b000010, 6'b000000, 0);
    run_instr(6'b111111, 6'b000000, 0);
    run_instr(6'b100011, 6'b000000, 1);

    // Reset mid-cycle during a store's write cycle.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ill = 1'b0;
    opcode = 6'b101011;
    repeat (3) @(negedge clk);
    #1 check("memwr before reset", {28'd0, state}, 32'd5);
    check("memwr mem_write", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b1;
    #1 check("async reset state", {28'd0, state}, 32'd0);
    check("async reset mem_write", {31'd0, mem_write}, 32'd0);
    check("async reset word", {9'd0, observed()},
          {9'd0, mk(0, 0,0,0,0,0,0,0, 0, 2'b01, 0, 2'b00, 4'b0010, 0)});
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'b000000, 6'b111000, 0);
    run_instr(6'b001100, 6'b000000, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      else fn = legal_fns[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_ill = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
